// File: rtl/clk_meter_if.sv
// Measurement bus of the clock meter. The stimulus side drives the square wave
// and the enable, and the meter returns the measured period and high time.
interface clk_meter_if #(
    parameter int CNT_W = 27
);
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             busy;

    modport master (
        output sig_in, enable,
        input  period, high_time, valid, timeout, busy
    );

    modport slave (
        input  sig_in, enable,
        output period, high_time, valid, timeout, busy
    );
endinterface

// File: rtl/clk_meter.sv
// Measures the period and the high time of a slow asynchronous square wave in
// clk cycles. A watchdog flags a missing input after TIMEOUT cycles.
module clk_meter #(
    parameter int CNT_W   = 27,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    clk_meter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);

    logic             sync1_r, sync2_r, hist_r;
    logic             rise_s, fall_s;
    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [CNT_W-1:0] high_r, high_next_s;
    logic             fall_seen_r, fall_seen_next_s;
    logic [CNT_W-1:0] period_r, period_next_s;
    logic [CNT_W-1:0] high_time_r, high_time_next_s;
    logic             valid_r, valid_next_s;
    logic             timeout_r, timeout_next_s;
    logic             busy_r;

    // Two-flop synchronizer plus history flop, so rise and fall share one latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            sync1_r <= bus.sig_in;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~hist_r;
    assign fall_s = ~sync2_r & hist_r;

    // Next-state logic; cnt_r always holds the cycles elapsed since the last edge t0.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        high_next_s      = high_r;
        fall_seen_next_s = fall_seen_r;
        period_next_s    = period_r;
        high_time_next_s = high_time_r;
        valid_next_s     = 1'b0;
        timeout_next_s   = timeout_r;
        case (state_r)
            IDLE: begin
                cnt_next_s       = CNT_ZERO;
                fall_seen_next_s = 1'b0;
                if (bus.enable) begin
                    state_next_s = ARM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARM: begin
                if (!bus.enable) begin
                    state_next_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (rise_s) begin
                    state_next_s     = MEAS;
                    cnt_next_s       = CNT_ONE;
                    fall_seen_next_s = 1'b0;
                end else if (cnt_r == CNT_TERM) begin
                    timeout_next_s = 1'b1;
                    cnt_next_s     = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            MEAS: begin
                if (!bus.enable) begin
                    state_next_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (rise_s) begin
                    // A rise on the terminal count still completes the measurement.
                    period_next_s    = cnt_r;
                    high_time_next_s = high_r;
                    valid_next_s     = 1'b1;
                    timeout_next_s   = 1'b0;
                    cnt_next_s       = CNT_ONE;
                    fall_seen_next_s = 1'b0;
                end else if (cnt_r == CNT_TERM) begin
                    state_next_s   = ARM;
                    timeout_next_s = 1'b1;
                    cnt_next_s     = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                    if (fall_s && !fall_seen_r) begin
                        high_next_s      = cnt_r;
                        fall_seen_next_s = 1'b1;
                    end else begin
                        high_next_s = high_r;
                    end
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            high_r      <= CNT_ZERO;
            fall_seen_r <= 1'b0;
            period_r    <= CNT_ZERO;
            high_time_r <= CNT_ZERO;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            high_r      <= high_next_s;
            fall_seen_r <= fall_seen_next_s;
            period_r    <= period_next_s;
            high_time_r <= high_time_next_s;
            valid_r     <= valid_next_s;
            timeout_r   <= timeout_next_s;
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign bus.period    = period_r;
    assign bus.high_time = high_time_r;
    assign bus.valid     = valid_r;
    assign bus.timeout   = timeout_r;
    assign bus.busy      = busy_r;
endmodule
